// File: rtl/drp_arbiter_if.sv
// Bundle of requester-side and GT DRP-side signals for drp_arbiter.
// slave modport is the arbiter's view; master modport is the view of whatever
// drives the requests and models the GT DRP port.
interface drp_arbiter_if #(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned ADDR_W = 9
);
   // Requester side
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ-1:0]        req_we_i;
   logic [N_REQ*ADDR_W-1:0] req_addr_i;
   logic [N_REQ*16-1:0]     req_di_i;
   logic [N_REQ-1:0]        ack_o;
   logic                    err_o;
   logic [15:0]             rdata_o;
   logic                    busy_o;
   // GT DRP side
   logic                    drpen_o;
   logic                    drpwe_o;
   logic [ADDR_W-1:0]       drpaddr_o;
   logic [15:0]             drpdi_o;
   logic                    drprdy_i;
   logic [15:0]             drpdo_i;

   modport slave (
      input  req_i, req_we_i, req_addr_i, req_di_i, drprdy_i, drpdo_i,
      output ack_o, err_o, rdata_o, busy_o, drpen_o, drpwe_o, drpaddr_o, drpdi_o
   );

   modport master (
      output req_i, req_we_i, req_addr_i, req_di_i, drprdy_i, drpdo_i,
      input  ack_o, err_o, rdata_o, busy_o, drpen_o, drpwe_o, drpaddr_o, drpdi_o
   );
endinterface

// File: rtl/drp_arbiter.sv
// Round-robin arbiter sharing one GT DRP port between N_REQ requesters.
// One access in flight at a time: IDLE -> ISSUE (drpen pulse) -> WAIT (drprdy) -> DONE (ack).
// Optional macro DRP_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYCLES cycles with err_o = 1.
module drp_arbiter #(
   parameter int unsigned N_REQ          = 3,
   parameter int unsigned ADDR_W         = 9,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input logic          drp_clk,
   input logic          rst_n,
   drp_arbiter_if.slave bus
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e            state_q;
   logic [IdxW-1:0]   rr_q;
   logic [IdxW-1:0]   grant_q;
   logic              we_q;
   logic [N_REQ-1:0]  ack_q;
   logic [15:0]       rdata_q;
   logic              drpen_q;
   logic              drpwe_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       di_q;

   logic              pick_valid;
   logic [IdxW-1:0]   pick_idx;
   logic [IdxW-1:0]   cand;

`ifdef DRP_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 10;
   logic [CntW-1:0] tmo_cnt_q;
   logic            err_q;
   assign bus.err_o = err_q;
`else
   // TIMEOUT_CYCLES only matters when the timeout is built in
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign bus.err_o      = 1'b0;
`endif

   // First set request at or above the rr pointer, wrapping
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IdxW'((32'(rr_q) + i) % N_REQ);
         if (!pick_valid && bus.req_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Access FSM; every output is a register updated here
   always_ff @(posedge drp_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rr_q      <= '0;
         grant_q   <= '0;
         we_q      <= 1'b0;
         ack_q     <= '0;
         rdata_q   <= '0;
         drpen_q   <= 1'b0;
         drpwe_q   <= 1'b0;
         addr_q    <= '0;
         di_q      <= '0;
`ifdef DRP_TIMEOUT_EN
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               // drprdy_i here is stray and ignored
               if (pick_valid) begin
                  grant_q <= pick_idx;
                  we_q    <= bus.req_we_i[pick_idx];
                  drpen_q <= 1'b1;
                  drpwe_q <= bus.req_we_i[pick_idx];
                  addr_q  <= bus.req_addr_i[pick_idx*ADDR_W +: ADDR_W];
                  di_q    <= bus.req_di_i[pick_idx*16 +: 16];
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               // A ready coincident with drpen cannot belong to this access
               drpen_q   <= 1'b0;
               drpwe_q   <= 1'b0;
`ifdef DRP_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
               state_q   <= StWait;
            end
            StWait: begin
               if (bus.drprdy_i) begin
                  if (!we_q) rdata_q <= bus.drpdo_i;
                  ack_q[grant_q] <= 1'b1;
`ifdef DRP_TIMEOUT_EN
                  err_q          <= 1'b0;
`endif
                  state_q        <= StDone;
               end
`ifdef DRP_TIMEOUT_EN
               else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  rdata_q        <= '0;
                  ack_q[grant_q] <= 1'b1;
                  err_q          <= 1'b1;
                  state_q        <= StDone;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CntW'(1);
               end
`endif
            end
            StDone: begin
               ack_q   <= '0;
`ifdef DRP_TIMEOUT_EN
               err_q   <= 1'b0;
`endif
               if (32'(grant_q) == N_REQ - 1) rr_q <= '0;
               else                           rr_q <= grant_q + IdxW'(1);
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ack_o     = ack_q;
   assign bus.rdata_o   = rdata_q;
   assign bus.busy_o    = (state_q != StIdle);
   assign bus.drpen_o   = drpen_q;
   assign bus.drpwe_o   = drpwe_q;
   assign bus.drpaddr_o = addr_q;
   assign bus.drpdi_o   = di_q;

endmodule

// File: tb/tb_drp_arbiter.sv
// Directed bench for drp_arbiter: vector table of single accesses plus
// hand-written stray-ready, reset-mid-WAIT, contention and timeout sequences.
module tb_drp_arbiter;

   localparam int unsigned NReq  = 3;
   localparam int unsigned AddrW = 9;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   drp_arbiter_if #(.N_REQ(NReq), .ADDR_W(AddrW)) bus ();

   drp_arbiter #(
      .N_REQ         (NReq),
      .ADDR_W        (AddrW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .drp_clk(clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned idx;
      logic        we;
      logic [8:0]  addr;
      logic [15:0] di;
      int unsigned dly;
      logic [15:0] dout;
      logic [2:0]  exp_ack;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where drpen_o is high
   task automatic wait_drpen(input string name);
      int n = 0;
      while (bus.drpen_o !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (bus.drpen_o !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s: drpen never seen got 0 expected 1", name);
      end
   endtask

   // From the drpen negedge: drprdy in cycle drpen+dly, returns in the ack cycle
   task automatic respond(input string name, input int unsigned dly, input logic [15:0] dout);
      @(negedge clk);
      check({name, "_drpen_single"}, bus.drpen_o, 1'b0);
      repeat (dly - 1) @(negedge clk);
      bus.drprdy_i = 1'b1;
      bus.drpdo_i  = dout;
      @(negedge clk);
      bus.drprdy_i = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ack"}, bus.ack_o, 3'b000);
      check({name, "_err"}, bus.err_o, 1'b0);
      check({name, "_rdata"}, bus.rdata_o, 16'h0000);
      check({name, "_busy"}, bus.busy_o, 1'b0);
      check({name, "_drpen"}, bus.drpen_o, 1'b0);
      check({name, "_drpwe"}, bus.drpwe_o, 1'b0);
      check({name, "_drpaddr"}, bus.drpaddr_o, 9'h000);
      check({name, "_drpdi"}, bus.drpdi_o, 16'h0000);
   endtask

   // Serve requester k of a contention run: read of 9'h010+k answered after 1 cycle
   task automatic serve(input int unsigned k);
      logic [15:0] dout;
      dout = 16'hC000 + 16'(k);
      wait_drpen($sformatf("serve%0d", k));
      check($sformatf("serve%0d_grant_addr", k), bus.drpaddr_o, 9'h010 + 9'(k));
      respond($sformatf("serve%0d", k), 1, dout);
      check($sformatf("serve%0d_ack", k), bus.ack_o, 3'b001 << k);
      check($sformatf("serve%0d_rdata", k), bus.rdata_o, dout);
      bus.req_i[k] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit stayed;
      vecs[0] = '{0, 1'b0, 9'h07C, 16'h1111, 3, 16'hA5A5, 3'b001, 16'hA5A5};
      vecs[1] = '{1, 1'b1, 9'h0A0, 16'h1234, 1, 16'hDEAD, 3'b010, 16'hA5A5};
      vecs[2] = '{2, 1'b0, 9'h1FF, 16'h2222, 2, 16'h5A0F, 3'b100, 16'h5A0F};
      vecs[3] = '{0, 1'b1, 9'h000, 16'hFFFF, 5, 16'h0BAD, 3'b001, 16'h5A0F};
      vecs[4] = '{1, 1'b0, 9'h155, 16'h3333, 1, 16'h0001, 3'b010, 16'h0001};

      bus.req_i      = '0;
      bus.req_we_i   = '0;
      bus.req_addr_i = {9'h1AA, 9'h0BB, 9'h0CC};
      bus.req_di_i   = {16'h9999, 16'h8888, 16'h7777};
      bus.drprdy_i   = 1'b0;
      bus.drpdo_i    = 16'h0000;
      rst_n          = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single accesses from the table
      foreach (vecs[i]) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         bus.req_we_i[vecs[i].idx]                 = vecs[i].we;
         bus.req_addr_i[vecs[i].idx*AddrW +: AddrW] = vecs[i].addr;
         bus.req_di_i[vecs[i].idx*16 +: 16]         = vecs[i].di;
         bus.req_i                                  = 3'b001 << vecs[i].idx;
         wait_drpen(nm);
         check({nm, "_drpwe"}, bus.drpwe_o, vecs[i].we);
         check({nm, "_drpaddr"}, bus.drpaddr_o, vecs[i].addr);
         check({nm, "_drpdi"}, bus.drpdi_o, vecs[i].di);
         respond(nm, vecs[i].dly, vecs[i].dout);
         check({nm, "_ack"}, bus.ack_o, vecs[i].exp_ack);
         check({nm, "_err"}, bus.err_o, 1'b0);
         check({nm, "_rdata"}, bus.rdata_o, vecs[i].exp_rdata);
         check({nm, "_busy_done"}, bus.busy_o, 1'b1);
         bus.req_i = '0;
         @(negedge clk);
         check({nm, "_ack_clear"}, bus.ack_o, 3'b000);
         check({nm, "_busy_idle"}, bus.busy_o, 1'b0);
      end

      // Stray ready in IDLE and in the ISSUE cycle
      bus.drprdy_i = 1'b1;
      bus.drpdo_i  = 16'hBEEF;
      @(negedge clk);
      bus.drprdy_i = 1'b0;
      check("stray_idle_ack", bus.ack_o, 3'b000);
      check("stray_idle_busy", bus.busy_o, 1'b0);
      bus.req_we_i[0]          = 1'b0;
      bus.req_addr_i[0 +: 9]   = 9'h033;
      bus.req_i                = 3'b001;
      wait_drpen("stray");
      bus.drprdy_i = 1'b1;
      bus.drpdo_i  = 16'hBAD1;
      @(negedge clk);
      bus.drprdy_i = 1'b0;
      check("stray_issue_ack", bus.ack_o, 3'b000);
      check("stray_issue_busy", bus.busy_o, 1'b1);
      @(negedge clk);
      check("stray_wait_ack", bus.ack_o, 3'b000);
      bus.drprdy_i = 1'b1;
      bus.drpdo_i  = 16'h7777;
      @(negedge clk);
      bus.drprdy_i = 1'b0;
      check("stray_ack", bus.ack_o, 3'b001);
      check("stray_rdata", bus.rdata_o, 16'h7777);
      bus.req_i = '0;
      @(negedge clk);

      // Reset in the middle of WAIT (rr pointer is 1 at this point)
      bus.req_we_i[1]        = 1'b0;
      bus.req_addr_i[9 +: 9] = 9'h0AB;
      bus.req_i              = 3'b010;
      wait_drpen("rstwait");
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_all_zero("rst_mid_wait");
      bus.req_i = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.drprdy_i = 1'b1;
      bus.drpdo_i  = 16'hFACE;
      @(negedge clk);
      bus.drprdy_i = 1'b0;
      check("late_rdy_ack", bus.ack_o, 3'b000);
      check("late_rdy_busy", bus.busy_o, 1'b0);
      check("late_rdy_rdata", bus.rdata_o, 16'h0000);

      // Contention straight after reset: order 0,1,2 then 0,2
      bus.req_we_i   = '0;
      bus.req_addr_i = {9'h012, 9'h011, 9'h010};
      bus.req_i      = 3'b111;
      serve(0);
      serve(1);
      serve(2);
      bus.req_i = 3'b101;
      serve(0);
      serve(2);
      check("contention_idle", bus.busy_o, 1'b0);

`ifdef DRP_TIMEOUT_EN
      begin
         int n;
         bus.req_addr_i[0 +: 9] = 9'h123;
         bus.req_i              = 3'b001;
         wait_drpen("tmo");
         n = 0;
         while (bus.ack_o === 3'b000 && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("tmo_latency", n, 17);
         check("tmo_ack", bus.ack_o, 3'b001);
         check("tmo_err", bus.err_o, 1'b1);
         check("tmo_rdata", bus.rdata_o, 16'h0000);
         bus.req_i = '0;
         @(negedge clk);
         check("tmo_err_clear", bus.err_o, 1'b0);
         bus.req_i = 3'b001;
         wait_drpen("tmo_limit");
         respond("tmo_limit", 16, 16'h4242);
         check("tmo_limit_ack", bus.ack_o, 3'b001);
         check("tmo_limit_err", bus.err_o, 1'b0);
         check("tmo_limit_rdata", bus.rdata_o, 16'h4242);
         bus.req_i = '0;
         @(negedge clk);
      end
`else
      bus.req_i = 3'b001;
      wait_drpen("hang");
      stayed = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (bus.busy_o !== 1'b1 || bus.ack_o !== 3'b000) stayed = 1'b0;
      end
      check("hang_busy_held", stayed, 1'b1);
      check("hang_err", bus.err_o, 1'b0);
      bus.req_i = '0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/drp_arbiter.md
Name: drp_arbiter

Overview:
- Shares one transceiver DRP port between N independent requesters, e.g. the debug VIO, a PRBS/eye-scan sequencer and a rate-change controller.
- Arbitrates round-robin and issues one DRP access at a time: single-cycle drpen/drpwe, wait for drprdy.
- Returns read data plus a one-cycle acknowledge to the granted requester.
- Sits between the requesters and the GT channel DRP pins, in the drp_clk domain.

Parameters:
- N_REQ, 3, number of requesters (1..8).
- ADDR_W, 9, DRP address width.
- TIMEOUT_CYCLES, 1023, drp_clk cycles to wait for drprdy_i before abort. Used only with the optional feature.

Ports:
- drp_clk  input  1  DRP clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  N_REQ  per-requester level request; held until its ack_o.
- req_we_i  input  N_REQ  1 = write, 0 = read; sampled at grant.
- req_addr_i  input  N_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- req_di_i  input  N_REQ*16  packed write data; requester k at [k*16 +: 16].
- ack_o  output  N_REQ  one-cycle completion pulse to the granted requester.
- err_o  output  1  valid with ack_o; 1 = access timed out.
- rdata_o  output  16  read data; valid with ack_o, held until the next ack.
- busy_o  output  1  high from grant through the ack cycle.
- drpen_o  output  1  DRP enable, one cycle per access.
- drpwe_o  output  1  DRP write enable, coincident with drpen_o for writes.
- drpaddr_o  output  ADDR_W  DRP address, held from ISSUE through WAIT.
- drpdi_o  output  16  DRP write data, held from ISSUE through WAIT.
- drprdy_i  input  1  DRP ready from the GT.
- drpdo_i  input  16  DRP read data, valid when drprdy_i = 1.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer = 0, grant = 0. All outputs 0: ack_o, err_o, rdata_o, busy_o, drpen_o, drpwe_o, drpaddr_o, drpdi_o.
- Reset mid-access abandons the access and generates no ack. The GT may still return a drprdy later; that is ignored per the IDLE rule.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_i is set, pick the first set bit searching from the rr pointer upward, with wrap.
  - Register grant index, req_we, addr and di; go to ISSUE.
  - drprdy_i in IDLE is ignored (stray ready).
- ISSUE (exactly 1 cycle):
  - drpen_o = 1; drpwe_o = latched we.
  - drpaddr_o/drpdi_o driven from latched values; go to WAIT.
  - A drprdy_i arriving in this same cycle is not accepted.
- WAIT:
  - drpen_o = drpwe_o = 0.
  - On drprdy_i: for a read, rdata_o <= drpdo_i; for a write, rdata_o is unchanged. Go to DONE.
  - Timeout handling: see Optional Feature.
- DONE (1 cycle):
  - ack_o[grant] = 1 with err_o valid.
  - rr pointer <= grant+1, wrapping at N_REQ; go to IDLE.
- Latency: request seen in IDLE at cycle 0 → drpen_o at cycle 1 → drprdy at cycle k ≥ 2 → ack at k+1.
- Requester rules:
  - Must drop req_i in the cycle after its ack.
  - req_i still high in the IDLE cycle after DONE counts as a new request, arbitrated normally. The rr pointer already points past it.
  - Dropping req_i before ack is illegal; the access still completes and acks.
- Fairness: a requester waits at most N_REQ-1 accesses after it asserts.
- Simultaneous requests: lowest index at or above the rr pointer wins. After reset, requester 0 wins.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: DRP_TIMEOUT_EN.
- Defined:
  - A 10-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without drprdy_i, go to DONE with err_o = 1 and rdata_o = 16'h0000.
  - drprdy_i in the cycle the count hits the limit wins: normal completion, err_o = 0.
- Undefined: no counter; WAIT holds until drprdy_i; err_o is tied 0.

Test Plan:
- Single read: req_i=3'b001, addr 9'h07C; GT returns drprdy at 3 cycles after drpen with drpdo=16'hA5A5 → one drpen pulse, drpwe=0, ack_o=3'b001 the next cycle, rdata_o=16'hA5A5, err_o=0.
- Single write: req 1 writes 16'h1234 to 9'h0A0 → drpen=drpwe=1 for one cycle, drpaddr=9'h0A0, drpdi=16'h1234; ack_o=3'b010; rdata_o unchanged.
- Contention: req_i=3'b111 held, each requester drops req_i after its ack → grant order 0, 1, 2. Then req 0 and 2 re-request → order 0, 2. Exactly one drpen per access; never two accesses outstanding.
- Stray ready: drprdy_i pulses in IDLE and in the ISSUE cycle → ignored; the access completes on the next legitimate drprdy.
- Timeout (DRP_TIMEOUT_EN, TIMEOUT_CYCLES=16): no drprdy → ack 17 cycles after drpen (16 WAIT cycles + 1 DONE) with err_o=1, rdata_o=0. Without the macro: busy_o stays high indefinitely.
- Reset mid-WAIT: assert rst_n low → all outputs 0 immediately. A late drprdy after release produces no ack. The next request is serviced normally, starting from requester 0.
